apb_bridge_controller: RTL and testbench
========================================

Name: apb_bridge_controller

Overview:
- Sequencing FSM for the AHB-to-APB bridge; sits behind the AHB slave interface.
- Consumes its valid strobe, registered write flag and pipelined address/data stages (haddr_1/haddr_2, hwdata_1/hwdata_2).
- Drives APB setup/enable phases to three peripherals and stretches the AHB transfer via hreadyout.
- Handles single reads, single writes and back-to-back pipelined writes.

Parameters:
- ADDR_W, 32, AHB/APB address width
- DATA_W, 32, AHB/APB data width
- NSLV, 3, number of APB peripherals (one-hot select width)

Ports:
- hclk  in  1  system clock; all state on rising edge
- hresetn  in  1  asynchronous active-low reset
- valid  in  1  qualified AHB transfer this cycle (hreadyin & NONSEQ/SEQ & in-map)
- hwrite  in  1  current AHB direction
- hwrite_reg  in  1  hwrite delayed one cycle
- haddr  in  ADDR_W  current AHB address
- haddr_1  in  ADDR_W  haddr delayed 1 cycle
- haddr_2  in  ADDR_W  haddr delayed 2 cycles
- hwdata  in  DATA_W  current AHB write data
- hwdata_1  in  DATA_W  hwdata delayed 1 cycle
- prdata  in  DATA_W  APB read data
- pselx  out  NSLV  one-hot APB select
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pwrite  out  1  APB direction
- penable  out  1  APB enable phase
- hreadyout  out  1  AHB ready back to master
- hrdata  out  DATA_W  AHB read data

Behaviour:
- Clock hclk; reset hresetn is asynchronous, active-low.
- Reset forces state IDLE and outputs: pselx=0, paddr=0, pwdata=0, pwrite=0, penable=0, hreadyout=1.
- All APB outputs and hreadyout are registered: loaded on the edge that enters a state, held for that state.
- pselx is decoded from the address loaded into paddr using the shared map:
  - 0x8000_0000..0x83FF_FFFF -> 001
  - 0x8400_0000..0x87FF_FFFF -> 010
  - 0x8800_0000..0x8BFF_FFFF -> 100
  - anything else -> 000
- hrdata = prdata combinationally (meaningful only when hreadyout=1 after RENABLE).
- States and transitions:
  - IDLE: valid&~hwrite->READ; valid&hwrite->WWAIT; else IDLE. Outputs: psel/penable 0, hreadyout 1.
  - WWAIT (write data not yet on bus): valid->WRITEP; else->WRITE. APB idle, hreadyout 1.
  - READ (setup): paddr=haddr, pwrite=0, pselx valid, penable=0, hreadyout=0. Always ->RENABLE.
  - RENABLE: penable=1, hreadyout=1. Then valid&~hwrite->READ; valid&hwrite->WWAIT; else IDLE.
  - WRITE (setup): paddr=haddr_1, pwdata=hwdata, pwrite=1, penable=0, hreadyout=0. valid->WENABLEP; else->WENABLE.
  - WRITEP (pipelined setup): paddr=haddr_1, pwdata=hwdata, pwrite=1, penable=0, hreadyout=0. Always ->WENABLEP.
  - WENABLE: penable=1, hreadyout=1. Exits as RENABLE.
  - WENABLEP: penable=1, hreadyout=1.
    - hwrite_reg&valid->WRITEP; hwrite_reg&~valid->WRITE; ~hwrite_reg->READ.
    - Address/data for the next setup come from haddr_2/hwdata_1, the pending stage.
- Latency:
  - Read: 2 APB cycles after valid (setup+enable); hreadyout low 1 cycle.
  - Single write: 3 cycles (wait+setup+enable).
- psel stays asserted between a setup and its enable; it deasserts in IDLE/WWAIT.
- Asserting valid during setup states is ignored; the master is stalled by hreadyout=0.
- Reset mid-transfer (any state) aborts at once to the reset values; no APB enable follows.
- Unused state encodings recover to IDLE on the next clock.

Decomposition:
- Package apb_bridge_pkg: state enum (IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP), address-map base/limit constants, htrans encodings.
- Sub-module apb_addr_decode: combinational address -> one-hot pselx, shared with the slave interface.

Test Plan:
- Reset: hresetn=0 in WRITE -> next sample state IDLE, pselx=000, penable=0, hreadyout=1, with no clock edge needed.
- Single read 0x8000_0010, prdata=0xDEAD_BEEF:
  - Cycle+1: pselx=001, penable=0, hreadyout=0.
  - Cycle+2: penable=1, hreadyout=1, hrdata=0xDEAD_BEEF.
- Single write 0x8400_0004, data 0x1234_5678:
  - Sequence WWAIT -> WRITE -> WENABLE.
  - WRITE: paddr=0x8400_0004, pwdata=0x1234_5678, pselx=010, pwrite=1.
  - Then IDLE.
- Back-to-back writes 0x8800_0000 then 0x8800_0004 (data A, B):
  - Sequence WWAIT -> WRITEP -> WENABLEP -> WRITE -> WENABLE.
  - Two APB enables occur, addresses in order, pwdata A then B.
- Write followed by read 0x8000_0008: WENABLEP with hwrite_reg=0 -> READ; paddr=0x8000_0008, pwrite=0.
- valid=0 with out-of-map address 0x9000_0000 -> FSM stays IDLE, pselx=000 for 10 cycles.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: FSM states,
// peripheral address map and AHB transfer encodings.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP
  } state_t;

  // Peripherals occupy consecutive 64 MiB windows starting at MAP_BASE.
  localparam logic [31:0] MAP_BASE  = 32'h8000_0000;
  localparam logic [31:0] MAP_SPAN  = 32'h0400_0000;
  localparam logic [31:0] MAP_LIMIT = 32'h8BFF_FFFF;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Address to one-hot peripheral select; also used by the AHB slave interface.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NSLV   = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NSLV-1:0]   sel
);

  for (genvar i = 0; i < NSLV; i++) begin : g_slv
    localparam logic [ADDR_W-1:0] LO = ADDR_W'(MAP_BASE + MAP_SPAN * 32'(i));
    localparam logic [ADDR_W-1:0] HI = LO + ADDR_W'(MAP_SPAN - 32'd1);
    assign sel[i] = (addr >= LO) && (addr <= HI);
  end

endmodule

// File: rtl/apb_bridge_controller.sv
// APB sequencing FSM of the AHB-to-APB bridge. All APB outputs and hreadyout
// are registered and loaded on the edge that enters the state they belong to.
module apb_bridge_controller
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwrite_reg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr_1,
  input  logic [ADDR_W-1:0] haddr_2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata_1,
  input  logic [DATA_W-1:0] prdata,
  output logic [NSLV-1:0]   pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              penable,
  output logic              hreadyout,
  output logic [DATA_W-1:0] hrdata
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] setup_addr;
  logic [DATA_W-1:0] setup_data;
  logic [NSLV-1:0]   setup_sel;

  assign hrdata = prdata;

  apb_addr_decode #(.ADDR_W(ADDR_W), .NSLV(NSLV)) u_dec (
    .addr(setup_addr),
    .sel (setup_sel)
  );

  always_comb begin
    state_d    = IDLE;
    setup_addr = haddr_1;
    setup_data = hwdata;
    case (state)
      IDLE, RENABLE, WENABLE: if (valid) state_d = hwrite ? WWAIT : READ;
      WWAIT:    state_d = valid ? WRITEP : WRITE;
      READ:     state_d = RENABLE;
      WRITE:    state_d = valid ? WENABLEP : WENABLE;
      WRITEP:   state_d = WENABLEP;
      WENABLEP: state_d = !hwrite_reg ? READ : (valid ? WRITEP : WRITE);
      default:  state_d = IDLE;
    endcase
    // Leaving a pipelined enable, the next transfer sits one stage deeper.
    if (state == WENABLEP) begin
      setup_addr = haddr_2;
      setup_data = hwdata_1;
    end else if (state_d == READ) begin
      setup_addr = haddr;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      pselx     <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      penable   <= 1'b0;
      hreadyout <= 1'b1;
    end else begin
      state <= state_d;
      case (state_d)
        READ, WRITE, WRITEP: begin
          pselx     <= setup_sel;
          paddr     <= setup_addr;
          pwrite    <= (state_d != READ);
          if (state_d != READ) pwdata <= setup_data;
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end
        RENABLE, WENABLE, WENABLEP: begin
          penable   <= 1'b1;
          hreadyout <= 1'b1;
        end
        default: begin
          pselx     <= '0;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_controller.sv
// Bench for apb_bridge_controller: directed vector table, reset-abort
// sequence, then randomized traffic against a reference model.
module tb_apb_bridge_controller;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        valid, hwrite, hwrite_reg;
  logic [31:0] haddr, haddr_1, haddr_2, hwdata, hwdata_1, prdata;
  logic [2:0]  pselx;
  logic [31:0] paddr, pwdata, hrdata;
  logic        pwrite, penable, hreadyout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  apb_bridge_controller dut (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
    .hwrite_reg(hwrite_reg), .haddr(haddr), .haddr_1(haddr_1), .haddr_2(haddr_2),
    .hwdata(hwdata), .hwdata_1(hwdata_1), .prdata(prdata), .pselx(pselx),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .penable(penable),
    .hreadyout(hreadyout), .hrdata(hrdata)
  );

  typedef struct {
    logic        v, hw, hwr;
    logic [31:0] a, a1, a2, d, d1, pr;
    logic [2:0]  e_sel;
    logic        e_pen, e_rdy, e_wr;
    logic [31:0] e_addr, e_data;
    logic        ck_a, ck_d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic hw, logic hwr, logic [31:0] a, logic [31:0] a1,
                              logic [31:0] a2, logic [31:0] d, logic [31:0] d1, logic [31:0] pr,
                              logic [2:0] es, logic ep, logic er, logic ew, logic [31:0] ea,
                              logic [31:0] ed, logic ca, logic cd);
    vec_t t;
    t.v = v; t.hw = hw; t.hwr = hwr; t.a = a; t.a1 = a1; t.a2 = a2; t.d = d; t.d1 = d1;
    t.pr = pr; t.e_sel = es; t.e_pen = ep; t.e_rdy = er; t.e_wr = ew; t.e_addr = ea;
    t.e_data = ed; t.ck_a = ca; t.ck_d = cd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    valid = t.v; hwrite = t.hw; hwrite_reg = t.hwr; haddr = t.a; haddr_1 = t.a1;
    haddr_2 = t.a2; hwdata = t.d; hwdata_1 = t.d1; prdata = t.pr;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pselx"}, 32'(pselx), 32'd0);
    chk({tag, ".penable"}, 32'(penable), 32'd0);
    chk({tag, ".hreadyout"}, 32'(hreadyout), 32'd1);
    chk({tag, ".pwrite"}, 32'(pwrite), 32'd0);
    chk({tag, ".paddr"}, paddr, 32'd0);
    chk({tag, ".pwdata"}, pwdata, 32'd0);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_WWAIT, M_READ, M_WRITE, M_WRITEP, M_RENABLE, M_WENABLE, M_WENABLEP} mst_t;
  mst_t        m;
  logic [2:0]  e_sel;
  logic        e_pen, e_rdy, e_wr;
  logic [31:0] e_addr, e_data;

  function automatic logic [2:0] map_sel(logic [31:0] a);
    int unsigned idx;
    if (a < 32'h8000_0000) return 3'b000;
    idx = (a - 32'h8000_0000) / 32'h0400_0000;
    return (idx < 3) ? 3'(1 << idx) : 3'b000;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 4);
    if (r == 4) return $urandom;
    return 32'h8000_0000 + r * 32'h0400_0000 + $urandom_range(0, 32'h03FF_FFFF);
  endfunction

  task automatic model_step();
    mst_t nx;
    logic from_pend = (m == M_WENABLEP);
    case (m)
      M_WWAIT:    nx = valid ? M_WRITEP : M_WRITE;
      M_READ:     nx = M_RENABLE;
      M_WRITE:    nx = valid ? M_WENABLEP : M_WENABLE;
      M_WRITEP:   nx = M_WENABLEP;
      M_WENABLEP: nx = !hwrite_reg ? M_READ : (valid ? M_WRITEP : M_WRITE);
      default:    nx = !valid ? M_IDLE : (hwrite ? M_WWAIT : M_READ);
    endcase
    case (nx)
      M_READ: begin
        e_addr = from_pend ? haddr_2 : haddr;
        e_wr = 0; e_sel = map_sel(e_addr); e_pen = 0; e_rdy = 0;
      end
      M_WRITE, M_WRITEP: begin
        e_addr = from_pend ? haddr_2 : haddr_1;
        e_data = from_pend ? hwdata_1 : hwdata;
        e_wr = 1; e_sel = map_sel(e_addr); e_pen = 0; e_rdy = 0;
      end
      M_RENABLE, M_WENABLE, M_WENABLEP: begin e_pen = 1; e_rdy = 1; end
      default: begin e_sel = 0; e_pen = 0; e_rdy = 1; end
    endcase
    m = nx;
  endtask

  initial begin
    hresetn = 1'b0;
    valid = 0; hwrite = 0; hwrite_reg = 0;
    haddr = 0; haddr_1 = 0; haddr_2 = 0; hwdata = 0; hwdata_1 = 0; prdata = 0;

    // single read
    tbl.push_back(mk(1,0,0,32'h8000_0010,0,0,0,0,0, 3'b001,0,0,0,32'h8000_0010,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,32'hDEAD_BEEF, 3'b001,1,1,0,32'h8000_0010,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 3'b000,0,1,0,0,0,0,0));
    // single write
    tbl.push_back(mk(1,1,0,32'h8400_0004,0,0,0,0,0, 3'b000,0,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,32'h8400_0004,0,32'h1234_5678,0,0, 3'b010,0,0,1,32'h8400_0004,32'h1234_5678,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 3'b010,1,1,1,32'h8400_0004,32'h1234_5678,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 3'b000,0,1,0,0,0,0,0));
    // back-to-back writes
    tbl.push_back(mk(1,1,0,32'h8800_0000,0,0,0,0,0, 3'b000,0,1,0,0,0,0,0));
    tbl.push_back(mk(1,1,1,32'h8800_0004,32'h8800_0000,0,32'hAAAA_0001,0,0, 3'b100,0,0,1,32'h8800_0000,32'hAAAA_0001,1,1));
    tbl.push_back(mk(0,1,1,0,0,0,0,0,0, 3'b100,1,1,1,32'h8800_0000,32'hAAAA_0001,1,1));
    tbl.push_back(mk(0,0,1,0,0,32'h8800_0004,0,32'hBBBB_0002,0, 3'b100,0,0,1,32'h8800_0004,32'hBBBB_0002,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 3'b100,1,1,1,32'h8800_0004,32'hBBBB_0002,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 3'b000,0,1,0,0,0,0,0));
    // write followed by read
    tbl.push_back(mk(1,1,0,32'h8400_0010,0,0,0,0,0, 3'b000,0,1,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,32'h8000_0008,32'h8400_0010,0,32'hCCCC_0003,0,0, 3'b010,0,0,1,32'h8400_0010,32'hCCCC_0003,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 3'b010,1,1,1,32'h8400_0010,32'hCCCC_0003,1,1));
    tbl.push_back(mk(0,0,0,0,0,32'h8000_0008,0,0,0, 3'b001,0,0,0,32'h8000_0008,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,32'h5A5A_A5A5, 3'b001,1,1,0,32'h8000_0008,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 3'b000,0,1,0,0,0,0,0));
    // chained reads at map edges; valid during setup is ignored
    tbl.push_back(mk(1,0,0,32'h83FF_FFFC,0,0,0,0,0, 3'b001,0,0,0,32'h83FF_FFFC,0,1,0));
    tbl.push_back(mk(1,0,0,32'h8BFF_FFFF,0,0,0,0,32'h0000_0011, 3'b001,1,1,0,32'h83FF_FFFC,0,1,0));
    tbl.push_back(mk(1,0,0,32'h8BFF_FFFF,0,0,0,0,0, 3'b100,0,0,0,32'h8BFF_FFFF,0,1,0));
    tbl.push_back(mk(1,0,0,32'h8C00_0000,0,0,0,0,32'h0000_0022, 3'b100,1,1,0,32'h8BFF_FFFF,0,1,0));
    tbl.push_back(mk(1,0,0,32'h8C00_0000,0,0,0,0,0, 3'b000,0,0,0,32'h8C00_0000,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,32'h0000_0033, 3'b000,1,1,0,32'h8C00_0000,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 3'b000,0,1,0,0,0,0,0));
    // idle bus with out-of-map address
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0,0,0,32'h9000_0000,0,0,0,0,0, 3'b000,0,1,0,0,0,0,0));

    repeat (2) @(posedge hclk);
    #1 chk_reset_vals("reset");
    @(negedge hclk) hresetn = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(posedge hclk);
      #1;
      chk($sformatf("v%0d.pselx", i), 32'(pselx), 32'(tbl[i].e_sel));
      chk($sformatf("v%0d.penable", i), 32'(penable), 32'(tbl[i].e_pen));
      chk($sformatf("v%0d.hreadyout", i), 32'(hreadyout), 32'(tbl[i].e_rdy));
      if (tbl[i].ck_a) begin
        chk($sformatf("v%0d.pwrite", i), 32'(pwrite), 32'(tbl[i].e_wr));
        chk($sformatf("v%0d.paddr", i), paddr, tbl[i].e_addr);
      end
      if (tbl[i].ck_d) chk($sformatf("v%0d.pwdata", i), pwdata, tbl[i].e_data);
      if (tbl[i].e_pen && !tbl[i].e_wr) chk($sformatf("v%0d.hrdata", i), hrdata, tbl[i].pr);
    end

    // reset asserted between edges while in a write setup
    drive(mk(1,1,0,32'h8400_0020,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    @(posedge hclk);
    #1 drive(mk(0,0,1,0,32'h8400_0020,0,32'h0000_0077,0,0, 0,0,0,0,0,0,0,0));
    @(posedge hclk);
    #1;
    chk("wr_setup.pselx", 32'(pselx), 32'd2);
    chk("wr_setup.hreadyout", 32'(hreadyout), 32'd0);
    #2 hresetn = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(posedge hclk);
    #1;
    chk("rst_hold.penable", 32'(penable), 32'd0);
    chk("rst_hold.pselx", 32'(pselx), 32'd0);
    @(negedge hclk) hresetn = 1'b1;

    // randomized traffic against the model
    m = M_IDLE; e_sel = 0; e_pen = 0; e_rdy = 1; e_wr = 0; e_addr = 0; e_data = 0;
    for (int c = 0; c < 600; c++) begin
      valid      = ($urandom_range(0, 99) < 60);
      hwrite     = 1'($urandom_range(0, 1));
      hwrite_reg = 1'($urandom_range(0, 1));
      haddr      = rand_addr();
      haddr_1    = rand_addr();
      haddr_2    = rand_addr();
      hwdata     = $urandom;
      hwdata_1   = $urandom;
      prdata     = $urandom;
      @(posedge hclk);
      model_step();
      #1;
      chk($sformatf("r%0d.pselx", c), 32'(pselx), 32'(e_sel));
      chk($sformatf("r%0d.penable", c), 32'(penable), 32'(e_pen));
      chk($sformatf("r%0d.hreadyout", c), 32'(hreadyout), 32'(e_rdy));
      if (m != M_IDLE && m != M_WWAIT) begin
        chk($sformatf("r%0d.pwrite", c), 32'(pwrite), 32'(e_wr));
        chk($sformatf("r%0d.paddr", c), paddr, e_addr);
        if (e_wr) chk($sformatf("r%0d.pwdata", c), pwdata, e_data);
        if (e_pen && !e_wr) chk($sformatf("r%0d.hrdata", c), hrdata, prdata);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
